// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory for the single-cycle RV64 core.
// Combinational loads with sign/zero extension; synchronous stores of 1/2/4/8 bytes.
module data_mem #(
    parameter int REG_WIDTH  = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 MemSign,
    input  logic [1:0]           MemWidth,
    input  logic [REG_WIDTH-1:0] wdata,
    input  logic [REG_WIDTH-1:0] full_addr,
    output logic [REG_WIDTH-1:0] rdata
);

    localparam int NBYTES = REG_WIDTH / 8;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    logic [7:0]            mem [DEPTH];

    logic [ADDR_WIDTH-1:0] base_addr_s;
    logic [ADDR_WIDTH-1:0] lane_addr_s [NBYTES];
    logic [NBYTES-1:0]     lane_en_s;
    logic [REG_WIDTH-1:0]  lane_bits_s;
    logic [REG_WIDTH-1:0]  raw_rd_s;
    logic [REG_WIDTH-1:0]  ext_rd_s;
    logic                  sign_bit_s;

    // Upper address bits alias onto the decoded range by design.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^full_addr[REG_WIDTH-1:ADDR_WIDTH];
    assign base_addr_s        = full_addr[ADDR_WIDTH-1:0];

    // Active byte lanes for an access of 2**w bytes.
    function automatic logic [NBYTES-1:0] width_lanes(input logic [1:0] w);
        logic [NBYTES-1:0] m;
        m = '0;
        for (int i = 0; i < NBYTES; i++) begin
            m[i] = (32'(i) < (32'd1 << w));
        end
        return m;
    endfunction

    // Per-lane byte address (wrapping modulo depth), lane mask and raw little-endian read data.
    always_comb begin
        lane_en_s   = width_lanes(MemWidth);
        lane_bits_s = '0;
        raw_rd_s    = '0;
        for (int i = 0; i < NBYTES; i++) begin
            lane_addr_s[i]          = base_addr_s + ADDR_WIDTH'(i);
            lane_bits_s[8*i +: 8]   = {8{lane_en_s[i]}};
            if (lane_en_s[i]) begin
                raw_rd_s[8*i +: 8] = mem[lane_addr_s[i]];
            end else begin
                raw_rd_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Pick the sign bit of the accessed field; a full-width access needs no fill.
    always_comb begin
        case (MemWidth)
            2'd0:    sign_bit_s = raw_rd_s[7];
            2'd1:    sign_bit_s = raw_rd_s[15];
            2'd2:    sign_bit_s = raw_rd_s[31];
            default: sign_bit_s = 1'b0;
        endcase
        ext_rd_s = raw_rd_s | ({REG_WIDTH{sign_bit_s & ~MemSign}} & ~lane_bits_s);
    end

    // Load result, forced to zero while in reset or when no load is requested.
    always_comb begin
        if (rst || !MemRead) begin
            rdata = '0;
        end else begin
            rdata = ext_rd_s;
        end
    end

    // Store path; reset only inhibits writes so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (!rst && MemWrite) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (lane_en_s[i]) begin
                    mem[lane_addr_s[i]] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed spec cases plus randomized traffic
// checked against a byte-array reference model.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic        MemSign;
    logic [1:0]  MemWidth;
    logic [63:0] wdata;
    logic [63:0] full_addr;
    logic [63:0] rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] model [1024];

    data_mem #(.REG_WIDTH(64), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSign(MemSign), .MemWidth(MemWidth), .wdata(wdata),
        .full_addr(full_addr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_read(input logic [63:0] a, input int w, input logic zext);
        int n;
        int base;
        logic [63:0] v;
        n    = 1 << w;
        base = int'(a % 64'd1024);
        v    = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(model[(base + i) % 1024]) << (8 * i));
        if (w < 3 && !zext && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] d, input int w);
        int base;
        base = int'(a % 64'd1024);
        for (int i = 0; i < (1 << w); i++) model[(base + i) % 1024] = d[8*i +: 8];
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input int w);
        @(negedge clk);
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        full_addr = a;
        wdata     = d;
        MemWidth  = 2'(w);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        if (!rst) model_write(a, d, w);
    endtask

    task automatic set_load(input logic [63:0] a, input int w, input logic zext);
        MemWrite  = 1'b0;
        MemRead   = 1'b1;
        full_addr = a;
        MemWidth  = 2'(w);
        MemSign   = zext;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b1; MemSign = 1'b0;
        MemWidth = 2'd3; wdata = 64'd0; full_addr = 64'd0;
        #2;
        vectors++;
        if (rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected %h", rdata, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_preload();
        dut.mem[0] = 8'h00; dut.mem[1] = 8'h01;
        model[0]   = 8'h00; model[1]   = 8'h01;
        set_load(64'h0, 0, 1'b1);
        vectors++;
        if (rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL preload_lbu0: got %h expected %h", rdata, 64'h0);
        end
        set_load(64'h1, 0, 1'b1);
        vectors++;
        if (rdata !== 64'h1) begin
            miscompares++;
            $display("FAIL preload_lbu1: got %h expected %h", rdata, 64'h1);
        end
    endtask

    task automatic test_sd_ld();
        do_store(64'h8, 64'h1122334455667788, 3);
        set_load(64'h8, 3, 1'b0);
        vectors++;
        if (rdata !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL sd_ld: got %h expected %h", rdata, 64'h1122334455667788);
        end
        vectors++;
        if (dut.mem[8] !== 8'h88) begin
            miscompares++;
            $display("FAIL sd_mem8: got %h expected %h", dut.mem[8], 8'h88);
        end
    endtask

    task automatic test_sw_lw();
        logic [31:0] above;
        above = {model[16'h27], model[16'h26], model[16'h25], model[16'h24]};
        do_store(64'h20, 64'hFFFFFFFF89ABCDEF, 2);
        set_load(64'h20, 2, 1'b0);
        vectors++;
        if (rdata !== 64'hFFFFFFFF89ABCDEF) begin
            miscompares++;
            $display("FAIL lw: got %h expected %h", rdata, 64'hFFFFFFFF89ABCDEF);
        end
        set_load(64'h20, 2, 1'b1);
        vectors++;
        if (rdata !== 64'h0000000089ABCDEF) begin
            miscompares++;
            $display("FAIL lwu: got %h expected %h", rdata, 64'h0000000089ABCDEF);
        end
        vectors++;
        if ({dut.mem[16'h27], dut.mem[16'h26], dut.mem[16'h25], dut.mem[16'h24]} !== above) begin
            miscompares++;
            $display("FAIL sw_untouched: got %h expected %h",
                     {dut.mem[16'h27], dut.mem[16'h26], dut.mem[16'h25], dut.mem[16'h24]}, above);
        end
    endtask

    task automatic test_sh_lh();
        do_store(64'h40, 64'hCDEF, 1);
        set_load(64'h40, 1, 1'b0);
        vectors++;
        if (rdata !== 64'hFFFFFFFFFFFFCDEF) begin
            miscompares++;
            $display("FAIL lh: got %h expected %h", rdata, 64'hFFFFFFFFFFFFCDEF);
        end
        set_load(64'h40, 1, 1'b1);
        vectors++;
        if (rdata !== 64'h000000000000CDEF) begin
            miscompares++;
            $display("FAIL lhu: got %h expected %h", rdata, 64'h000000000000CDEF);
        end
    endtask

    task automatic test_sb_lb();
        do_store(64'h60, 64'hAA, 0);
        set_load(64'h60, 0, 1'b0);
        vectors++;
        if (rdata !== 64'hFFFFFFFFFFFFFFAA) begin
            miscompares++;
            $display("FAIL lb: got %h expected %h", rdata, 64'hFFFFFFFFFFFFFFAA);
        end
        set_load(64'h60, 0, 1'b1);
        vectors++;
        if (rdata !== 64'hAA) begin
            miscompares++;
            $display("FAIL lbu: got %h expected %h", rdata, 64'hAA);
        end
    endtask

    task automatic test_read_disable();
        set_load(64'h8, 3, 1'b0);
        MemRead = 1'b0;
        #1;
        vectors++;
        if (rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL read_disable: got %h expected %h", rdata, 64'd0);
        end
    endtask

    task automatic test_reset_write();
        @(negedge clk);
        rst = 1'b1;
        do_store(64'h8, 64'hDEADBEEFCAFEF00D, 3);
        set_load(64'h8, 3, 1'b0);
        vectors++;
        if (rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_rdata_high: got %h expected %h", rdata, 64'd0);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (rdata !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL reset_no_write: got %h expected %h", rdata, 64'h1122334455667788);
        end
    endtask

    task automatic test_wrap();
        do_store(64'h3FC, 64'h0102030405060708, 3);
        set_load(64'h3FC, 3, 1'b0);
        vectors++;
        if (rdata !== 64'h0102030405060708) begin
            miscompares++;
            $display("FAIL wrap_ld: got %h expected %h", rdata, 64'h0102030405060708);
        end
        vectors++;
        if ({dut.mem[3], dut.mem[0], dut.mem[16'h3FF], dut.mem[16'h3FC]} !== 32'h01040508) begin
            miscompares++;
            $display("FAIL wrap_bytes: got %h expected %h",
                     {dut.mem[3], dut.mem[0], dut.mem[16'h3FF], dut.mem[16'h3FC]}, 32'h01040508);
        end
    endtask

    task automatic test_alias();
        set_load(64'h400, 3, 1'b0);
        vectors++;
        if (rdata !== model_read(64'h0, 3, 1'b0)) begin
            miscompares++;
            $display("FAIL alias_400: got %h expected %h", rdata, model_read(64'h0, 3, 1'b0));
        end
        do_store(64'hFFFF000000000410, 64'h0BADC0DE, 2);
        set_load(64'h10, 2, 1'b1);
        vectors++;
        if (rdata !== 64'h0BADC0DE) begin
            miscompares++;
            $display("FAIL alias_store: got %h expected %h", rdata, 64'h0BADC0DE);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] old_v;
        for (int k = 0; k < 8; k++) begin
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            old_v = model_read(a, 3, 1'b0);
            @(negedge clk);
            MemRead = 1'b1; MemWrite = 1'b1; MemWidth = 2'd3; MemSign = 1'b0;
            full_addr = a; wdata = d;
            #1;
            vectors++;
            if (rdata !== old_v) begin
                miscompares++;
                $display("FAIL rdw_old: got %h expected %h", rdata, old_v);
            end
            @(posedge clk);
            #1;
            model_write(a, d, 3);
            vectors++;
            if (rdata !== d) begin
                miscompares++;
                $display("FAIL rdw_new: got %h expected %h", rdata, d);
            end
            MemWrite = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] exp_v;
        int          w;
        logic        s;
        for (int k = 0; k < 400; k++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a = a % 64'd1024;
            w = int'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                do_store(a, {$urandom, $urandom}, w);
            end else begin
                set_load(a, w, s);
                exp_v = model_read(a, w, s);
                vectors++;
                if (rdata !== exp_v) begin
                    miscompares++;
                    $display("FAIL random_load: addr %h w %0d s %0d got %h expected %h",
                             a, w, s, rdata, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 128; i++) do_store(64'(8 * i), {$urandom, $urandom}, 3);
        test_preload();
        test_sd_ld();
        test_sw_lw();
        test_sh_lh();
        test_sb_lb();
        test_read_disable();
        test_reset_write();
        test_wrap();
        test_alias();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
